// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte bus between the UART receiver and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] data;
    logic                      data_valid;
    logic                      frame_err;
    logic                      busy;

    modport master (
        input  rx,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer; resets to all ones so an idle-high line stays idle.
module uart_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes rx, validates the start bit, samples mid-bit,
// and reports each frame with a one-cycle data_valid or frame_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master bus
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W    = 3;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_param
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic                      rx_s;
    uart_state_e               state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      data_valid_q;
    logic                      frame_err_q;
    logic                      busy_q;
    logic                      half_hit;
    logic                      bit_hit;

    uart_sync2 #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    assign half_hit = (cnt == CNT_W'(HALF_BIT - 1));
    assign bit_hit  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Frame FSM; the counter restarts at every sample point so samples stay mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_q       <= shreg;
                            data_valid_q <= 1'b1;
                            state        <= IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low break must release before a new start edge counts.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 16 and the minimum of 4.
module tb_uart_rx;
    import uart_pkg::*;

    typedef struct packed {
        logic       err;
        logic [7:0] d;
    } exp_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     errors;
    longint cyc;
    exp_t   q16[$];
    exp_t   q4[$];
    exp_t   e16;
    exp_t   e4;
    longint vt16[$];
    int     nv16, nf16, nv4, nf4;

    uart_rx_if if16();
    uart_rx_if if4();

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
    uart_rx #(.CLKS_PER_BIT(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input bit use4, input logic v);
        if (use4) if4.rx = v;
        else      if16.rx = v;
    endtask

    task automatic send_frame(input bit use4, input logic [7:0] b, input logic stop, input int cpb);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_rx(use4, f[i]);
            repeat (cpb / 2) @(negedge clk);
            if (i == 5) check(use4 ? "busy_mid4" : "busy_mid16", 32'(use4 ? if4.busy : if16.busy), 1);
            repeat (cpb - cpb / 2) @(negedge clk);
        end
    endtask

    // Output monitors: every pulse must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (reset && (if16.data_valid || if16.frame_err)) begin
            check("excl16", 32'(if16.data_valid & if16.frame_err), 0);
            if (q16.size() == 0) begin
                check("unexpected_pulse16", 1, 0);
            end else begin
                e16 = q16.pop_front();
                check("kind16", 32'(if16.frame_err), 32'(e16.err));
                check("data16", 32'(if16.data), 32'(e16.d));
            end
            if (if16.data_valid) begin
                nv16++;
                vt16.push_back(cyc);
            end else begin
                nf16++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset && (if4.data_valid || if4.frame_err)) begin
            check("excl4", 32'(if4.data_valid & if4.frame_err), 0);
            if (q4.size() == 0) begin
                check("unexpected_pulse4", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check("kind4", 32'(if4.frame_err), 32'(e4.err));
                check("data4", 32'(if4.data), 32'(e4.d));
            end
            if (if4.data_valid) nv4++;
            else                nf4++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] f;
        checks = 0; errors = 0; cyc = 0;
        nv16 = 0; nf16 = 0; nv4 = 0; nf4 = 0;
        reset = 1'b0;
        if16.rx = 1'b1;
        if4.rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(if16.data), 0);
        check("rst_valid", 32'(if16.data_valid), 0);
        check("rst_ferr",  32'(if16.frame_err), 0);
        check("rst_busy",  32'(if16.busy), 0);
        check("rst_data4", 32'(if4.data), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte
        q16.push_back('{err: 1'b0, d: 8'hA5});
        send_frame(1'b0, 8'hA5, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("single_cnt", nv16, 1);
        check("single_data", 32'(if16.data), 32'hA5);
        check("single_busy_end", 32'(if16.busy), 0);

        // Back-to-back, no idle gap
        vt16.delete();
        q16.push_back('{err: 1'b0, d: 8'h00});
        q16.push_back('{err: 1'b0, d: 8'hFF});
        q16.push_back('{err: 1'b0, d: 8'h3C});
        send_frame(1'b0, 8'h00, 1'b1, 16);
        send_frame(1'b0, 8'hFF, 1'b1, 16);
        send_frame(1'b0, 8'h3C, 1'b1, 16);
        repeat (10) @(negedge clk);
        check("b2b_cnt", nv16, 4);
        check("b2b_times", vt16.size(), 3);
        if (vt16.size() == 3) begin
            check("b2b_gap01", 32'(vt16[1] - vt16[0]), 160);
            check("b2b_gap12", 32'(vt16[2] - vt16[1]), 160);
        end

        // Framing error followed by a 40-bit break
        q16.push_back('{err: 1'b1, d: 8'h3C});
        send_frame(1'b0, 8'h55, 1'b0, 16);
        repeat (40 * 16) @(negedge clk);
        check("brk_busy", 32'(if16.busy), 1);
        check("brk_ferr_cnt", nf16, 1);
        check("brk_valid_cnt", nv16, 4);
        set_rx(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("brk_release_busy", 32'(if16.busy), 0);
        check("brk_data_held", 32'(if16.data), 32'h3C);
        check("brk_valid_cnt2", nv16, 4);
        q16.push_back('{err: 1'b0, d: 8'h81});
        send_frame(1'b0, 8'h81, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("after_brk_cnt", nv16, 5);
        check("after_brk_data", 32'(if16.data), 32'h81);

        // Glitch shorter than half a bit
        set_rx(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        set_rx(1'b0, 1'b1);
        repeat (8 + 3) @(negedge clk);
        check("glitch_busy", 32'(if16.busy), 0);
        repeat (200) @(negedge clk);
        check("glitch_valid_cnt", nv16, 5);
        check("glitch_ferr_cnt", nf16, 1);

        // Reset during bit 4 of 0xC3
        f = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            set_rx(1'b0, f[i]);
            repeat (16) @(negedge clk);
        end
        set_rx(1'b0, f[5]);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(if16.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_data",  32'(if16.data), 0);
        check("midrst_valid", 32'(if16.data_valid), 0);
        check("midrst_ferr",  32'(if16.frame_err), 0);
        check("midrst_busy",  32'(if16.busy), 0);
        set_rx(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("aborted_no_pulse", nv16 + nf16, 6);
        q16.push_back('{err: 1'b0, d: 8'h12});
        send_frame(1'b0, 8'h12, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("post_rst_cnt", nv16, 6);
        check("post_rst_data", 32'(if16.data), 32'h12);

        // Minimum oversampling ratio
        q4.push_back('{err: 1'b0, d: 8'h96});
        q4.push_back('{err: 1'b0, d: 8'h69});
        send_frame(1'b1, 8'h96, 1'b1, 4);
        send_frame(1'b1, 8'h69, 1'b1, 4);
        repeat (10) @(negedge clk);
        check("min_cnt", nv4, 2);
        check("min_ferr", nf4, 0);
        check("min_data", 32'(if4.data), 32'h69);

        check("q16_empty", q16.size(), 0);
        check("q4_empty", q4.size(), 0);
        check("ferr_total16", nf16, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
